// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: op-code encoding shared by the gate datapath and its users.
package logic_gate_pkg;

  localparam int unsigned OP_W = 3;

  // Bitwise function select carried with every operand beat
  typedef enum logic [OP_W-1:0] {
    OP_NAND  = 3'b000,
    OP_NOR   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSA = 3'b111
  } logic_op_e;

endpackage

// File: rtl/logic_gate_pipe_if.sv
// logic_gate_pipe_if: operand/result handshake bundle for logic_gate_pipe.
// Optional macro LOGIC_GATE_PIPE_PARITY_EN adds the out_par result bit.
interface logic_gate_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();
  import logic_gate_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic_op_e        in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_ones;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic             out_par;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_ones, out_par
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_ones, out_par
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_ones
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_ones
  );
`endif

endinterface

// File: rtl/logic_gate_func.sv
// logic_gate_func: combinational WIDTH-bit bitwise function selected by op.
module logic_gate_func
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic_op_e        op,
  output logic [WIDTH-1:0] y
);

  // Apply the selected function; b is unused for NOT A and PASS A
  always_comb begin
    y = '0;
    case (op)
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSA: y = a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipeline applying a per-beat bitwise
// function, with result flags and a saturating completed-result counter.
// Optional macro LOGIC_GATE_PIPE_PARITY_EN adds a registered parity output.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_gate_pipe_if.slave bus,
  output logic [CNT_W-1:0] txn_count
);

  logic             en1;
  logic             en2;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic_op_e        op1_q, op1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] y2_q, y2_d;
  logic             zero2_q, zero2_d;
  logic             ones2_q, ones2_d;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic             par2_q, par2_d;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] func_y;

  logic_gate_func #(
    .WIDTH (WIDTH)
  ) u_func (
    .a  (a1_q),
    .b  (b1_q),
    .op (op1_q),
    .y  (func_y)
  );

  // Stage advance enables; S1 may refill in the same cycle S2 drains
  always_comb begin
    en2 = !v2_q || bus.out_ready;
    en1 = !v1_q || en2;
  end

  // S1 next state: operands and op are captured only on an input transfer
  always_comb begin
    v1_d  = v1_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    op1_d = op1_q;
    if (en1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        a1_d  = bus.in_a;
        b1_d  = bus.in_b;
        op1_d = bus.in_op;
      end
    end
  end

  // S2 next state: result and flags load only from a valid S1 beat
  always_comb begin
    v2_d    = v2_q;
    y2_d    = y2_q;
    zero2_d = zero2_q;
    ones2_d = ones2_q;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    par2_d  = par2_q;
`endif
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        y2_d    = func_y;
        zero2_d = ~|func_y;
        ones2_d = &func_y;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        par2_d  = ^func_y;
`endif
      end
    end
  end

  // Saturating count of output handshakes
  always_comb begin
    cnt_d = cnt_q;
    if (v2_q && bus.out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      op1_q   <= OP_NAND;
      v2_q    <= 1'b0;
      y2_q    <= '0;
      zero2_q <= 1'b1;
      ones2_q <= 1'b0;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
      par2_q  <= 1'b0;
`endif
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      op1_q   <= op1_d;
      v2_q    <= v2_d;
      y2_q    <= y2_d;
      zero2_q <= zero2_d;
      ones2_q <= ones2_d;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
      par2_q  <= par2_d;
`endif
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = en1;
  assign bus.out_valid = v2_q;
  assign bus.out_y     = y2_q;
  assign bus.out_zero  = zero2_q;
  assign bus.out_ones  = ones2_q;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  assign bus.out_par   = par2_q;
`endif
  assign txn_count     = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed self-checking bench for logic_gate_pipe.
// Honours LOGIC_GATE_PIPE_PARITY_EN when the build defines it.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  logic clk;
  logic rst_n;
  logic [15:0] txn_count;
  logic [2:0]  txn_sat;

  int checks;
  int failures;

  logic_gate_pipe_if #(.WIDTH(8)) bus ();
  logic_gate_pipe_if #(.WIDTH(8)) sif ();

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .txn_count (txn_count)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sif),
    .txn_count (txn_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat tables for streamed runs and per-cycle observations after each edge
  logic [7:0] bv_a  [0:127];
  logic [7:0] bv_b  [0:127];
  logic_op_e  bv_op [0:127];
  logic       obs_v [0:129];
  logic [7:0] obs_y [0:129];
  logic       obs_z [0:129];
  logic       obs_o [0:129];

  // Reference truth table for the eight op codes
  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return ~(a & b);
      3'd1:    return ~(a | b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // Stream n beats back-to-back with out_ready high, recording outputs after every edge
  task automatic run_stream(input int n);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = bv_a[0];
    bus.in_b      = bv_b[0];
    bus.in_op     = bv_op[0];
    for (int j = 0; j <= n; j++) begin
      @(posedge clk); #1;
      obs_v[j] = bus.out_valid;
      obs_y[j] = bus.out_y;
      obs_z[j] = bus.out_zero;
      obs_o[j] = bus.out_ones;
      if (j + 1 < n) begin
        bus.in_a  = bv_a[j+1];
        bus.in_b  = bv_b[j+1];
        bus.in_op = bv_op[j+1];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    obs_v[n+1] = bus.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_y !== 8'h00) begin
      failures++;
      $display("FAIL reset_out: valid=%b y=%h required valid=0 y=00", bus.out_valid, bus.out_y);
    end
    checks++;
    if (bus.out_zero !== 1'b1 || bus.out_ones !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: zero=%b ones=%b required zero=1 ones=0", bus.out_zero, bus.out_ones);
    end
    checks++;
    if (txn_count !== 16'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cnt_ready: txn=%0d in_ready=%b required txn=0 in_ready=1", txn_count, bus.in_ready);
    end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    checks++;
    if (bus.out_par !== 1'b0) begin
      failures++;
      $display("FAIL reset_par: par=%b required 0", bus.out_par);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_truth_table();
    logic [7:0] vals_a [0:3];
    logic [7:0] vals_b [0:3];
    logic [7:0] e;
    int idx;
    vals_a = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    vals_b = '{8'h00, 8'hFF, 8'h5A, 8'h0F};
    for (int o = 0; o < 8; o++) begin
      for (int ai = 0; ai < 4; ai++) begin
        for (int bi = 0; bi < 4; bi++) begin
          idx = o * 16 + ai * 4 + bi;
          bv_a[idx]  = vals_a[ai];
          bv_b[idx]  = vals_b[bi];
          bv_op[idx] = logic_op_e'(3'(o));
        end
      end
    end
    run_stream(128);
    checks++;
    if (obs_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL tt_latency: out_valid=%b one cycle after first transfer, required 0", obs_v[0]);
    end
    for (int j = 1; j <= 128; j++) begin
      e = ref_op(3'(bv_op[j-1]), bv_a[j-1], bv_b[j-1]);
      checks++;
      if (obs_v[j] !== 1'b1 || obs_y[j] !== e) begin
        failures++;
        $display("FAIL tt_beat%0d: valid=%b y=%h required valid=1 y=%h", j - 1, obs_v[j], obs_y[j], e);
      end
      checks++;
      if (obs_z[j] !== (e == 8'h00) || obs_o[j] !== (e == 8'hFF)) begin
        failures++;
        $display("FAIL tt_flags%0d: zero=%b ones=%b for y=%h", j - 1, obs_z[j], obs_o[j], e);
      end
    end
    checks++;
    if (obs_y[12] !== 8'hFA) begin
      failures++;
      $display("FAIL tt_nand_a5_0f: y=%h required fa", obs_y[12]);
    end
    checks++;
    if (obs_v[129] !== 1'b0 || txn_count !== 16'd128) begin
      failures++;
      $display("FAIL tt_drain: valid=%b txn=%0d required valid=0 txn=128", obs_v[129], txn_count);
    end
  endtask

  task automatic test_flags();
    bv_a[0] = 8'hF0; bv_b[0] = 8'h0F; bv_op[0] = OP_AND;
    bv_a[1] = 8'hF0; bv_b[1] = 8'h0F; bv_op[1] = OP_OR;
    bv_a[2] = 8'h55; bv_b[2] = 8'h55; bv_op[2] = OP_XOR;
    run_stream(3);
    checks++;
    if (obs_y[1] !== 8'h00 || obs_z[1] !== 1'b1 || obs_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL flags_and: y=%h zero=%b ones=%b required 00/1/0", obs_y[1], obs_z[1], obs_o[1]);
    end
    checks++;
    if (obs_y[2] !== 8'hFF || obs_z[2] !== 1'b0 || obs_o[2] !== 1'b1) begin
      failures++;
      $display("FAIL flags_or: y=%h zero=%b ones=%b required ff/0/1", obs_y[2], obs_z[2], obs_o[2]);
    end
    checks++;
    if (obs_y[3] !== 8'h00 || obs_z[3] !== 1'b1 || obs_o[3] !== 1'b0) begin
      failures++;
      $display("FAIL flags_xor: y=%h zero=%b ones=%b required 00/1/0", obs_y[3], obs_z[3], obs_o[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_y [0:3];
    exp_y = '{8'hFF, 8'h00, 8'hC3, 8'h3C};
    for (int i = 0; i < 4; i++) begin
      bv_a[i] = 8'h3C;
      bv_b[i] = 8'hC3;
    end
    bv_op[0] = OP_NAND; bv_op[1] = OP_NOR; bv_op[2] = OP_NOTA; bv_op[3] = OP_PASSA;
    run_stream(4);
    for (int j = 1; j <= 4; j++) begin
      checks++;
      if (obs_v[j] !== 1'b1 || obs_y[j] !== exp_y[j-1]) begin
        failures++;
        $display("FAIL b2b_beat%0d: valid=%b y=%h required valid=1 y=%h", j - 1, obs_v[j], obs_y[j], exp_y[j-1]);
      end
    end
    checks++;
    if (obs_v[5] !== 1'b0 || txn_count !== 16'd135) begin
      failures++;
      $display("FAIL b2b_drain: valid=%b txn=%0d required valid=0 txn=135", obs_v[5], txn_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_y [0:4];
    logic in_x;
    int ip;
    int opp;
    exp_y = '{8'hEF, 8'hEE, 8'hED, 8'hEC, 8'hEB};
    ip  = 0;
    opp = 0;
    for (int cyc = 0; cyc < 40 && opp < 5; cyc++) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (ip < 5);
      bus.in_a      = 8'(ip);
      bus.in_b      = 8'h10;
      bus.in_op     = OP_NOR;
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (bus.in_ready !== 1'b0 || ip != 2) begin
          failures++;
          $display("FAIL bp_stall_in cyc%0d: in_ready=%b accepted=%0d required in_ready=0 accepted=2", cyc, bus.in_ready, ip);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_y !== 8'hEF || bus.out_zero !== 1'b0) begin
          failures++;
          $display("FAIL bp_hold cyc%0d: valid=%b y=%h required valid=1 y=ef", cyc, bus.out_valid, bus.out_y);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_release: in_ready=%b required 1", bus.in_ready);
        end
      end
      in_x = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_y !== exp_y[opp]) begin
          failures++;
          $display("FAIL bp_order%0d: y=%h required %h", opp, bus.out_y, exp_y[opp]);
        end
        opp++;
      end
      @(posedge clk);
      if (in_x) ip++;
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (opp != 5) begin
      failures++;
      $display("FAIL bp_timeout: received %0d beats required 5", opp);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || txn_count !== 16'd140) begin
      failures++;
      $display("FAIL bp_drain: valid=%b txn=%0d required valid=0 txn=140", bus.out_valid, txn_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.in_op = OP_AND;
    @(posedge clk); #1;
    bus.in_a = 8'h0F; bus.in_b = 8'hF0; bus.in_op = OP_OR;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== 8'hFF) begin
      failures++;
      $display("FAIL rm_inflight: valid=%b y=%h required valid=1 y=ff", bus.out_valid, bus.out_y);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_y !== 8'h00 || bus.out_zero !== 1'b1) begin
      failures++;
      $display("FAIL rm_async: valid=%b y=%h zero=%b required 0/00/1", bus.out_valid, bus.out_y, bus.out_zero);
    end
    checks++;
    if (txn_count !== 16'd0 || bus.out_ones !== 1'b0) begin
      failures++;
      $display("FAIL rm_cnt: txn=%0d ones=%b required txn=0 ones=0", txn_count, bus.out_ones);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rm_stale%0d: valid=%b in_ready=%b required valid=0 in_ready=1", k, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_saturation();
    logic [2:0] e_cnt;
    logic [9:0] par_tbl;
    par_tbl = 10'b01_1001_0110;
    sif.out_ready = 1'b1;
    sif.in_valid  = 1'b1;
    sif.in_a      = 8'd0;
    sif.in_b      = 8'h00;
    sif.in_op     = OP_PASSA;
    for (int j = 0; j <= 13; j++) begin
      @(posedge clk); #1;
      e_cnt = (j <= 1) ? 3'd0 : ((j - 1 > 7) ? 3'd7 : 3'(j - 1));
      checks++;
      if (txn_sat !== e_cnt) begin
        failures++;
        $display("FAIL sat_cnt cyc%0d: txn=%0d required %0d", j, txn_sat, e_cnt);
      end
      if (j >= 1 && j <= 10) begin
        checks++;
        if (sif.out_valid !== 1'b1 || sif.out_y !== 8'(j - 1)) begin
          failures++;
          $display("FAIL sat_beat%0d: valid=%b y=%h required valid=1 y=%h", j - 1, sif.out_valid, sif.out_y, 8'(j - 1));
        end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        checks++;
        if (sif.out_par !== par_tbl[j-1]) begin
          failures++;
          $display("FAIL sat_par%0d: par=%b required %b", j - 1, sif.out_par, par_tbl[j-1]);
        end
`endif
      end
      if (j + 1 < 10) begin
        sif.in_a = 8'(j + 1);
      end else begin
        sif.in_valid = 1'b0;
      end
    end
    checks++;
    if (txn_sat !== 3'd7 || sif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sat_final: txn=%0d valid=%b required txn=7 valid=0", txn_sat, sif.out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.in_op     = OP_NAND;
    bus.out_ready = 1'b0;
    sif.in_valid  = 1'b0;
    sif.in_a      = 8'h00;
    sif.in_b      = 8'h00;
    sif.in_op     = OP_NAND;
    sif.out_ready = 1'b0;

    test_reset();
    test_truth_table();
    test_flags();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
